// File: rtl/tx_packet_queue.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_queue
// Desc     : Packet queue in front of the serial Transmitter. It holds
//            {addr,data} entries and presents the oldest one on send/taddr/tdata.
//            Optional macro TXQ_OVERFLOW_FLAG_EN adds a sticky overflow output.
// Revision : 1.0  initial release
// ============================================================================
module tx_packet_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          push,
    input  logic [1:0]    paddr,
    input  logic [3:0]    pdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    input  logic          ready,
    output logic          send,
    output logic [1:0]    taddr,
    output logic [3:0]    tdata
`ifdef TXQ_OVERFLOW_FLAG_EN
    ,
    output logic          overflow
`endif
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [5:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign send      = ~empty;
    assign taddr     = r_mem[r_rp][5:4];
    assign tdata     = r_mem[r_rp][3:0];

    // full is the pre-edge value, so a push while full is refused even if a pop frees a slot.
    assign w_do_push = push & ~full & ~clear;
    assign w_do_pop  = send & ready & ~clear;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wp] <= {paddr, pdata};
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_do_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef TXQ_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_overflow <= 1'b0;
        end else if (push & full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_packet_queue
// Desc     : Randomised self-checking bench for tx_packet_queue against a
//            queue-based reference model (honours TXQ_OVERFLOW_FLAG_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_packet_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock;
    logic          clear;
    logic          push;
    logic [1:0]    paddr;
    logic [3:0]    pdata;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ready;
    logic          send;
    logic [1:0]    taddr;
    logic [3:0]    tdata;
`ifdef TXQ_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    tx_packet_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock    (clock),
        .clear    (clear),
        .push     (push),
        .paddr    (paddr),
        .pdata    (pdata),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ready    (ready),
        .send     (send),
        .taddr    (taddr),
        .tdata    (tdata)
`ifdef TXQ_OVERFLOW_FLAG_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] mq[$];
    logic       m_ovf = 1'b0;
    int         busy  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full",  32'(full),  32'(mq.size() == DEPTH));
        check("send",  32'(send),  32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("taddr", 32'(taddr), 32'(mq[0][5:4]));
            check("tdata", 32'(tdata), 32'(mq[0][3:0]));
        end
`ifdef TXQ_OVERFLOW_FLAG_EN
        check("overflow", 32'(overflow), 32'(m_ovf));
`endif
    endtask

    // Drive one clock of inputs, advance the model at the edge, check at the falling edge.
    task automatic cycle(input logic c, input logic p, input logic [1:0] a,
                         input logic [3:0] d, input logic r);
        clear = c; push = p; paddr = a; pdata = d; ready = r;
        @(posedge clock);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            automatic bit was_full = (mq.size() == DEPTH);
            if (mq.size() != 0 && r) void'(mq.pop_front());
            if (p && !was_full) mq.push_back({a, d});
            if (p && was_full) m_ovf = 1'b1;
        end
        @(negedge clock);
        compare();
    endtask

    // Transmitter-like ready: low for six clocks after each accepted packet.
    task automatic tx_cycle(input logic c, input logic p, input logic [1:0] a, input logic [3:0] d);
        automatic logic r = (busy == 0);
        automatic bit   acc = r && (mq.size() != 0) && !c;
        cycle(c, p, a, d, r);
        if (c) busy = 0;
        else if (acc) busy = 6;
        else if (busy > 0) busy--;
    endtask

    initial begin
        clear = 1'b1; push = 1'b0; paddr = '0; pdata = '0; ready = 1'b0;

        cycle(1, 1, 2'd3, 4'hF, 1);
        cycle(1, 1, 2'd3, 4'hF, 1);

        cycle(0, 1, 2'd2, 4'hA, 1);
        cycle(0, 0, 2'd0, 4'h0, 1);

        for (int i = 1; i <= 5; i++) cycle(0, 1, 2'd1, 4'(i), 0);
        cycle(0, 1, 2'd0, 4'h9, 1);
        cycle(1, 0, 2'd0, 4'h0, 0);

        busy = 0;
        for (int i = 0; i < 3; i++) tx_cycle(0, 1, 2'(i), 4'(i + 4));
        for (int i = 0; i < 24; i++) tx_cycle(0, 0, 2'd0, 4'h0);

        cycle(0, 1, 2'd3, 4'h1, 0);
        cycle(0, 1, 2'd3, 4'h2, 0);
        for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 1, 2'(i), 4'(i), 1);

        busy = 0;
        for (int i = 0; i < 3; i++) tx_cycle(0, 1, 2'd1, 4'(i));
        tx_cycle(0, 0, 2'd0, 4'h0);
        tx_cycle(1, 0, 2'd0, 4'h0);

        for (int i = 0; i < 600; i++) begin
            automatic logic c = ($urandom_range(0, 59) == 0);
            automatic logic p = ($urandom_range(0, 99) < ((i < 300) ? 70 : 35));
            automatic logic [1:0] a = 2'($urandom);
            automatic logic [3:0] d = 4'($urandom);
            if (i % 200 < 100) cycle(c, p, a, d, 1'($urandom));
            else tx_cycle(c, p, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
